// File: rtl/riscv_commit_checker_if.sv
// Bus between the checkpoint checker and whoever drives it: table config,
// run control, the observed core signals, and the run status/result.
interface riscv_commit_checker_if #(
  parameter int IDX_W = 6
);
  // Handshake: START is a one-cycle request. It is accepted whenever BUSY is
  // low and ignored while BUSY is high. DONE is the level response; it rises
  // with PASS or FAIL and holds with all results until RST or the next START.
  logic             CFG_WE;
  logic [IDX_W-1:0] CFG_IDX;
  logic [31:0]      CFG_NUM_INST;
  logic [31:0]      CFG_ANS;
  logic [IDX_W-1:0] CFG_CNT;
  logic             START;
  logic [31:0]      NUM_INST;
  logic [31:0]      OUTPUT_PORT;
  logic             HALT;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic             FAIL;
  logic [1:0]       FAIL_CODE;
  logic [IDX_W-1:0] FAIL_IDX;
  logic [31:0]      FAIL_VAL;
  logic [IDX_W-1:0] PASS_CNT;
  logic [31:0]      CYCLE_CNT;
  logic [1:0]       STATE;

  modport master (
    output CFG_WE, CFG_IDX, CFG_NUM_INST, CFG_ANS, CFG_CNT, START,
           NUM_INST, OUTPUT_PORT, HALT,
    input  BUSY, DONE, PASS, FAIL, FAIL_CODE, FAIL_IDX, FAIL_VAL,
           PASS_CNT, CYCLE_CNT, STATE
  );

  modport slave (
    input  CFG_WE, CFG_IDX, CFG_NUM_INST, CFG_ANS, CFG_CNT, START,
           NUM_INST, OUTPUT_PORT, HALT,
    output BUSY, DONE, PASS, FAIL, FAIL_CODE, FAIL_IDX, FAIL_VAL,
           PASS_CNT, CYCLE_CNT, STATE
  );
endinterface

// File: rtl/riscv_commit_checker.sv
// Checkpoint checker for the RISC-V core: compares (NUM_INST, OUTPUT_PORT)
// against a programmed table. Optional run timeout behind `CHK_TIMEOUT_EN.
module riscv_commit_checker #(
  parameter int NUM_CHK = 32,
  parameter int IDX_W   = 6,
  parameter int TIMEOUT = 1000000
) (
  input logic                   CLK,
  input logic                   RST,
  riscv_commit_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam int               AW        = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;
  localparam logic [IDX_W-1:0] NUM_CHK_I = IDX_W'(NUM_CHK);

  logic [31:0] tbl_num [NUM_CHK];
  logic [31:0] tbl_ans [NUM_CHK];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       code_q, code_d;
  logic [31:0]      val_q, val_d;
  logic [31:0]      cyc_q, cyc_d;

  logic [AW-1:0]    rd_sel;
  logic [31:0]      cur_num;
  logic [31:0]      cur_ans;
  logic             pending;
  logic             fail_now;

  // The table survives reset so a board can be re-run without reprogramming.
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && bus.CFG_WE && bus.CFG_IDX < NUM_CHK_I) begin
      tbl_num[bus.CFG_IDX[AW-1:0]] <= bus.CFG_NUM_INST;
      tbl_ans[bus.CFG_IDX[AW-1:0]] <= bus.CFG_ANS;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    code_d   = code_q;
    val_d    = val_q;
    cyc_d    = cyc_q;
    fail_now = 1'b0;
    rd_sel   = ptr_q[AW-1:0];
    cur_num  = tbl_num[rd_sel];
    cur_ans  = tbl_ans[rd_sel];
    pending  = (ptr_q < cnt_q);

    case (state_q)
      S_RUN: begin
        cyc_d = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
        if (pending && bus.NUM_INST == cur_num) begin
          if (bus.OUTPUT_PORT == cur_ans) begin
            ptr_d = ptr_q + IDX_W'(1);
          end else begin
            fail_now = 1'b1;
            code_d   = 2'd1;
          end
        end else if (pending && bus.NUM_INST > cur_num) begin
          fail_now = 1'b1;
          code_d   = 2'd2;
        end
        // HALT is judged against the pointer after this cycle's scoring.
        if (!fail_now && bus.HALT) begin
          if (ptr_d == cnt_q) begin
            state_d = S_PASS;
          end else begin
            fail_now = 1'b1;
            code_d   = 2'd2;
          end
        end
`ifdef CHK_TIMEOUT_EN
        else if (!fail_now && cyc_d == 32'(TIMEOUT)) begin
          fail_now = 1'b1;
          code_d   = 2'd3;
        end
`endif
        if (fail_now) begin
          state_d = S_FAIL;
          idx_d   = ptr_d;
          val_d   = bus.OUTPUT_PORT;
        end
      end
      default: begin
        if (bus.START) begin
          state_d = S_RUN;
          cnt_d   = (bus.CFG_CNT > NUM_CHK_I) ? NUM_CHK_I : bus.CFG_CNT;
          ptr_d   = '0;
          cyc_d   = '0;
          code_d  = '0;
          idx_d   = '0;
          val_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      val_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      val_q   <= val_d;
      cyc_q   <= cyc_d;
    end
  end

`ifndef CHK_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT);
`endif

  assign bus.BUSY      = (state_q == S_RUN);
  assign bus.DONE      = (state_q == S_PASS) || (state_q == S_FAIL);
  assign bus.PASS      = (state_q == S_PASS);
  assign bus.FAIL      = (state_q == S_FAIL);
  assign bus.FAIL_CODE = code_q;
  assign bus.FAIL_IDX  = idx_q;
  assign bus.FAIL_VAL  = val_q;
  assign bus.PASS_CNT  = ptr_q;
  assign bus.CYCLE_CNT = cyc_q;
  assign bus.STATE     = state_q;

endmodule

// File: doc/riscv_commit_checker.md
# riscv_commit_checker

Synthesizable checkpoint checker downstream of the RISCV_TOP core. It samples the core's `NUM_INST`, `OUTPUT_PORT` and `HALT` every cycle and compares them against a programmable table of (instruction count, expected output) checkpoints. It reports pass/fail with a failure cause and index, so the same checks run on FPGA or in gate-level simulation without a behavioural bench.

## Interface
- `NUM_CHK`, 32: number of checkpoint table entries.
- `IDX_W`, 6: index width; must satisfy 2^IDX_W > NUM_CHK.
- `TIMEOUT`, 1000000: cycle limit in RUN (used only when `CHK_TIMEOUT_EN` is defined).

Ports:
- `CLK` in 1: clock.
- `RST` in 1: synchronous, active-high reset.
- `CFG_WE` in 1: table write strobe; honoured only in IDLE.
- `CFG_IDX` in IDX_W: table write index; writes with `CFG_IDX >= NUM_CHK` are ignored.
- `CFG_NUM_INST` in 32: checkpoint instruction count.
- `CFG_ANS` in 32: expected `OUTPUT_PORT` value.
- `CFG_CNT` in IDX_W: number of valid entries, sampled on START; values above `NUM_CHK` are clamped to `NUM_CHK`.
- `START` in 1: one-cycle pulse; begins a run.
- `NUM_INST` in 32: core retired-instruction count.
- `OUTPUT_PORT` in 32: core output port.
- `HALT` in 1: core halt flag.
- `BUSY` out 1: high in RUN.
- `DONE` out 1: high in PASS or FAIL.
- `PASS` out 1: run passed.
- `FAIL` out 1: run failed.
- `FAIL_CODE` out 2: failure cause. 0 none, 1 mismatch, 2 skipped/incomplete, 3 timeout.
- `FAIL_IDX` out IDX_W: table index being checked when the failure occurred.
- `FAIL_VAL` out 32: `OUTPUT_PORT` sampled at the failure.
- `PASS_CNT` out IDX_W: checkpoints passed so far.
- `CYCLE_CNT` out 32: cycles spent in RUN; saturates at 0xFFFFFFFF.

## Operation
- FSM states: IDLE, RUN, PASS, FAIL. On RST: IDLE, and every output is 0. The table is not cleared by reset.
- IDLE:
  - `CFG_WE` writes entry `CFG_IDX`.
  - `START` goes to RUN; it latches `cnt = CFG_CNT` and clears `ptr`, `PASS_CNT`, `CYCLE_CNT` and the FAIL_* outputs.
- RUN, evaluated every cycle in this priority order:
  1. `ptr < cnt` and `NUM_INST == tbl_num[ptr]`:
     - If `OUTPUT_PORT == tbl_ans[ptr]`: increment `ptr` and `PASS_CNT`.
     - Otherwise go to FAIL with code 1.
  2. `ptr < cnt` and `NUM_INST > tbl_num[ptr]` (unsigned): go to FAIL with code 2, because a checkpoint was skipped.
  3. `HALT`:
     - If `ptr` equals `cnt` after this cycle's update, go to PASS.
     - Otherwise go to FAIL with code 2.
  4. Timeout (see Configuration).
- A checkpoint match and `HALT` in the same cycle: the checkpoint is scored first, then `HALT` is judged with the updated `ptr`.
- Once `ptr == cnt`, further `NUM_INST` values are ignored until `HALT` arrives.
- `cnt == 0`: the run passes on the first `HALT`.
- Table entries must be programmed in strictly ascending `tbl_num` order. Out-of-order tables cause code 2 failures; this is a configuration error, not a checker error.
- On entering FAIL: `FAIL_IDX = ptr`, `FAIL_VAL = OUTPUT_PORT` of the deciding cycle.
- PASS and FAIL are sticky. All outputs hold until RST or a new `START`; `START` in PASS or FAIL begins a new run.
- In RUN, `START` and `CFG_WE` are ignored.
- `CYCLE_CNT` increments once per RUN cycle, including the deciding cycle, then freezes.

## Timing
- Inputs are sampled on the rising edge of `CLK`; all outputs are registered.
- `DONE`/`PASS`/`FAIL` rise exactly 1 cycle after the deciding sample.
- `BUSY` rises the cycle after `START` and falls together with the `DONE` rise.
- A table write in cycle N is visible to a run started in cycle N+1.
- RST asserted mid-run: the next state is IDLE and all outputs are 0; no partial result is retained.
- The core is expected to change `NUM_INST` at most once per cycle. A run is only judged on values present at clock edges.

## Configuration
- `CHK_TIMEOUT_EN` defined:
  - In RUN, if `CYCLE_CNT` reaches `TIMEOUT` with no other exit, go to FAIL with code 3 and `FAIL_IDX = ptr`.
  - This has the lowest priority, so a same-cycle checkpoint failure or `HALT` wins.
- Not defined:
  - No timeout logic; code 3 is never produced.
  - The `TIMEOUT` parameter is unused.
  - RUN exits only via checkpoint or `HALT`.

## Test plan
- **All pass.** Load (4,0x0eec), (6,0x0000), (8,0x0001); START with `CFG_CNT=3`; drive matching values, then `HALT` at `NUM_INST`=10 → `PASS=1`, `PASS_CNT=3`, `FAIL_CODE=0`, `DONE` 1 cycle after `HALT`.
- **Mismatch.** Same table; at `NUM_INST=6` drive `OUTPUT_PORT=0x0005` → `FAIL=1`, `FAIL_CODE=1`, `FAIL_IDX=1`, `FAIL_VAL=0x5`, `PASS_CNT=1`.
- **Skipped checkpoint.** `NUM_INST` jumps 4→7 → `FAIL_CODE=2`, `FAIL_IDX=1`. Separately, `HALT` after only 2 of 3 checkpoints → `FAIL_CODE=2`, `FAIL_IDX=2`.
- **Simultaneous match and HALT.** Last checkpoint (8,0x0001) matches in the same cycle as `HALT=1` → `PASS=1`, `PASS_CNT=3`.
- **Timeout.** With `CHK_TIMEOUT_EN`, `TIMEOUT=50`, `NUM_INST` held at 0 → `FAIL_CODE=3` and `CYCLE_CNT=50`. Without the macro, no FAIL after 100 cycles.
- **Reset and restart.** RST mid-run at `PASS_CNT=2` → all outputs 0 next cycle; the table is still intact. A new `START` with the same stimulus → `PASS`.
